// File: rtl/ttl_74169_chain.sv
// ttl_74169_chain
//   Synchronous up/down presettable binary counter made of NIBBLES cascaded
//   74169-style 4-bit stages. The stages are chained internally in the same
//   way as the discrete parts: ENP fans out to every stage, and each stage's
//   T input comes from the ripple-carry output of the stage below it.
//
// Parameters
//   NIBBLES     number of 4-bit stages (W = 4*NIBBLES, must be >= 1)
//   DELAY_RISE  rise delay (ns) of the discrete part; the RTL is zero-delay
//   DELAY_FALL  fall delay (ns) of the discrete part; the RTL is zero-delay
//
// Ports
//   Clk            rising-edge clock
//   Clear_bar      synchronous clear, active-low (highest priority)
//   Load_bar       synchronous parallel load of D, active-low
//   ENP_bar        count enable P, active-low, to all stages
//   ENT_bar        count enable T, active-low, to stage 0
//   U_D            direction, 1 = up, 0 = down
//   D[W-1:0]       preset value
//   Q[W-1:0]       count; stage i is Q[4i+3:4i]
//   Stage_RCO_bar  per-stage ripple carry, active-low, combinational
//   RCO_bar        chain ripple carry (= Stage_RCO_bar[NIBBLES-1])
//   Wrap           only with TTL_74169_WRAP_FLAG_EN defined: sticky flag,
//                  set when the whole chain wraps, cleared by clear or load

// One 4-bit stage: state register plus its terminal-count detect. The T gating
// and the carry chain live in the top so the chain is evaluated in one place.
module ttl_74169_stage (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       load_n,
    input  logic       enp_n,
    input  logic       t_n,
    input  logic       up,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       tc
);
    logic [3:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (!load_n)
            q_d = d;
        else if (!enp_n && !t_n)
            q_d = up ? q_q + 4'd1 : q_q - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!clear_n) q_q <= 4'h0;
        else          q_q <= q_d;
    end

    assign q  = q_q;
    assign tc = up ? (q_q == 4'hF) : (q_q == 4'h0);
endmodule

module ttl_74169_chain #(
    parameter int NIBBLES    = 2,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic                 Clk,
    input  logic                 Clear_bar,
    input  logic                 Load_bar,
    input  logic                 ENP_bar,
    input  logic                 ENT_bar,
    input  logic                 U_D,
    input  logic [4*NIBBLES-1:0] D,
    output logic [4*NIBBLES-1:0] Q,
    output logic [NIBBLES-1:0]   Stage_RCO_bar,
`ifdef TTL_74169_WRAP_FLAG_EN
    output logic                 Wrap,
`endif
    output logic                 RCO_bar
);
    // The delays describe the discrete part's timing only; they are checked
    // here so a bad value is caught at elaboration instead of silently kept.
    if (NIBBLES < 1 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_param
        $error("ttl_74169_chain: NIBBLES must be >= 1 and delays >= 0");
    end

    logic [NIBBLES-1:0] stage_t_n;
    logic [NIBBLES-1:0] stage_tc;
    logic [NIBBLES-1:0] rco_n;

    // Carry chain: a stage ripples out only when its own T is active and it
    // sits at terminal count, and that ripple is the next stage's T.
    always_comb begin
        logic t_n;
        t_n       = ENT_bar;
        stage_t_n = '1;
        rco_n     = '1;
        for (int i = 0; i < NIBBLES; i++) begin
            stage_t_n[i] = t_n;
            rco_n[i]     = ~(~t_n & stage_tc[i]);
            t_n          = rco_n[i];
        end
    end

    for (genvar i = 0; i < NIBBLES; i++) begin : g_stage
        ttl_74169_stage u_stage (
            .clk     (Clk),
            .clear_n (Clear_bar),
            .load_n  (Load_bar),
            .enp_n   (ENP_bar),
            .t_n     (stage_t_n[i]),
            .up      (U_D),
            .d       (D[4*i +: 4]),
            .q       (Q[4*i +: 4]),
            .tc      (stage_tc[i])
        );
    end

    assign Stage_RCO_bar = rco_n;
    assign RCO_bar       = rco_n[NIBBLES-1];

`ifdef TTL_74169_WRAP_FLAG_EN
    logic wrap_q, wrap_d;

    // The whole chain wraps exactly when it counts while the last ripple
    // carry is active (every stage at terminal count with T enabled).
    always_comb begin
        wrap_d = wrap_q;
        if (!Load_bar)
            wrap_d = 1'b0;
        else if (!ENP_bar && !rco_n[NIBBLES-1])
            wrap_d = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (!Clear_bar) wrap_q <= 1'b0;
        else            wrap_q <= wrap_d;
    end

    assign Wrap = wrap_q;
`endif
endmodule

// File: tb/tb_ttl_74169_chain.sv
module tb_ttl_74169_chain;
    localparam int N = 2;
    localparam int W = 4 * N;

    logic         Clk = 1'b0;
    logic         Clear_bar = 1'b1, Load_bar = 1'b1, ENP_bar = 1'b1, ENT_bar = 1'b1, U_D = 1'b1;
    logic [W-1:0] D = '0;
    logic [W-1:0] Q;
    logic [N-1:0] Stage_RCO_bar;
    logic         RCO_bar;
`ifdef TTL_74169_WRAP_FLAG_EN
    logic         Wrap;
`endif

    int errors = 0;
    int checks = 0;

    ttl_74169_chain #(.NIBBLES(N), .DELAY_RISE(0), .DELAY_FALL(0)) dut (
        .Clk           (Clk),
        .Clear_bar     (Clear_bar),
        .Load_bar      (Load_bar),
        .ENP_bar       (ENP_bar),
        .ENT_bar       (ENT_bar),
        .U_D           (U_D),
        .D             (D),
        .Q             (Q),
        .Stage_RCO_bar (Stage_RCO_bar),
`ifdef TTL_74169_WRAP_FLAG_EN
        .Wrap          (Wrap),
`endif
        .RCO_bar       (RCO_bar)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the chain is one W-bit number.
    int unsigned m_q;
    bit          m_wrap;
    localparam int unsigned MAXV = (1 << W) - 1;

    function automatic logic [N-1:0] ref_srco(input int unsigned q, input bit ent_n, input bit up);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            int unsigned m;
            int unsigned low;
            m   = 1 << (4 * (i + 1));
            low = q % m;
            r[i] = !(!ent_n && (up ? (low == m - 1) : (low == 0)));
        end
        return r;
    endfunction

    task automatic model_edge(input bit clr_n, ld_n, enp_n, ent_n, up, input int unsigned d);
        if (!clr_n) begin
            m_q = 0; m_wrap = 0;
        end else if (!ld_n) begin
            m_q = d; m_wrap = 0;
        end else if (!enp_n && !ent_n) begin
            if (up) begin
                if (m_q == MAXV) m_wrap = 1;
                m_q = (m_q + 1) % (MAXV + 1);
            end else begin
                if (m_q == 0) m_wrap = 1;
                m_q = (m_q + MAXV) % (MAXV + 1);
            end
        end
    endtask

    typedef struct {
        bit           clr_n, ld_n, enp_n, ent_n, up;
        logic [W-1:0] d;
        logic [W-1:0] exp_q;
        logic [N-1:0] exp_srco;
        bit           exp_wrap;
    } vec_t;

    initial begin
        vec_t vt[$];
        vt.push_back('{0, 1, 0, 0, 1, 8'h00, 8'h00, 2'b11, 0}); // clear
        vt.push_back('{1, 0, 0, 0, 1, 8'h0E, 8'h0E, 2'b11, 0}); // load 0E
        vt.push_back('{1, 1, 0, 0, 1, 8'h00, 8'h0F, 2'b10, 0});
        vt.push_back('{1, 1, 0, 0, 1, 8'h00, 8'h10, 2'b11, 0}); // cascade
        vt.push_back('{1, 0, 0, 0, 1, 8'hFF, 8'hFF, 2'b00, 0}); // load FF
        vt.push_back('{1, 1, 0, 0, 1, 8'h00, 8'h00, 2'b11, 1}); // up wrap
        vt.push_back('{1, 0, 0, 0, 0, 8'h01, 8'h01, 2'b11, 0}); // load 01 down
        vt.push_back('{1, 1, 0, 0, 0, 8'h00, 8'h00, 2'b00, 0});
        vt.push_back('{1, 1, 0, 0, 0, 8'h00, 8'hFF, 2'b11, 1}); // down wrap
        vt.push_back('{1, 0, 0, 0, 1, 8'h3F, 8'h3F, 2'b10, 0}); // load 3F
        vt.push_back('{1, 1, 1, 0, 1, 8'h00, 8'h3F, 2'b10, 0}); // ENP off
        vt.push_back('{1, 1, 0, 1, 1, 8'h00, 8'h3F, 2'b11, 0}); // ENT off
        vt.push_back('{0, 0, 0, 0, 1, 8'hA5, 8'h00, 2'b11, 0}); // clear beats load
        vt.push_back('{1, 0, 0, 0, 1, 8'hA5, 8'hA5, 2'b11, 0}); // load beats count
        vt.push_back('{1, 0, 1, 0, 1, 8'h00, 8'h00, 2'b11, 0}); // load 00

        foreach (vt[k]) begin
            @(negedge Clk);
            Clear_bar = vt[k].clr_n; Load_bar = vt[k].ld_n; ENP_bar = vt[k].enp_n;
            ENT_bar = vt[k].ent_n; U_D = vt[k].up; D = vt[k].d;
            @(posedge Clk); #1;
            chk($sformatf("vec%0d_q", k), 32'(Q), 32'(vt[k].exp_q));
            chk($sformatf("vec%0d_srco", k), 32'(Stage_RCO_bar), 32'(vt[k].exp_srco));
            chk($sformatf("vec%0d_rco", k), 32'(RCO_bar), 32'(vt[k].exp_srco[N-1]));
`ifdef TTL_74169_WRAP_FLAG_EN
            chk($sformatf("vec%0d_wrap", k), 32'(Wrap), 32'(vt[k].exp_wrap));
`endif
        end

        // Direction flip at Q=00 while holding: carry reacts in the same cycle,
        // and the very next count goes down.
        @(negedge Clk);
        Load_bar = 1; ENP_bar = 1; ENT_bar = 0; U_D = 1; #1;
        chk("flip_rco_up", 32'(RCO_bar), 32'd1);
        U_D = 0; #1;
        chk("flip_rco_down", 32'(RCO_bar), 32'd0);
        ENP_bar = 0;
        @(posedge Clk); #1;
        chk("flip_q", 32'(Q), 32'hFF);

        // Randomized run against the arithmetic model.
        @(negedge Clk);
        Clear_bar = 0; Load_bar = 1;
        @(posedge Clk); #1;
        m_q = 0; m_wrap = 0;
        for (int n = 0; n < 400; n++) begin
            int unsigned sel;
            @(negedge Clk);
            Clear_bar = ($urandom_range(0, 24) != 0);
            Load_bar  = ($urandom_range(0, 9) != 0);
            ENP_bar   = ($urandom_range(0, 3) == 0);
            ENT_bar   = ($urandom_range(0, 3) == 0);
            U_D       = $urandom_range(0, 1);
            sel = $urandom_range(0, 4);
            D = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : (sel == 2) ? 8'hF0 :
                (sel == 3) ? 8'h0F : 8'($urandom);
            #1;
            chk("rnd_srco_pre", 32'(Stage_RCO_bar), 32'(ref_srco(m_q, ENT_bar, U_D)));
            @(posedge Clk);
            model_edge(Clear_bar, Load_bar, ENP_bar, ENT_bar, U_D, 32'(D));
            #1;
            chk("rnd_q", 32'(Q), m_q);
            chk("rnd_rco", 32'(RCO_bar), 32'(ref_srco(m_q, ENT_bar, U_D) >> (N - 1)));
`ifdef TTL_74169_WRAP_FLAG_EN
            chk("rnd_wrap", 32'(Wrap), 32'(m_wrap));
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
